// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port framebuffer RAM between video
// scanout (absolute priority) and the host port. Read data is steered back
// to its owner by a tag pipeline that is as deep as the RAM read latency.
// Also keeps a per-frame count of host stall cycles for debug.
module fb_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,   // RAM read latency, 1..4
  parameter int CNT_W  = 16
) (
  input  logic              CLK_25MHZ,
  input  logic              RESET,        // synchronous, active low
  // video scanout fetch
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  input  logic              VID_BLANK,
  input  logic              FRAME_START,
  output logic [DATA_W-1:0] VID_RDATA,
  output logic              VID_RVALID,
  // host port
  input  logic              HOST_VALID,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  output logic              HOST_READY,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_RVALID,
  input  logic              BLANK_ONLY,
  // RAM side
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  // debug
  output logic [CNT_W-1:0]  STALL_CNT
);

  // Owner of a read in flight; at most one bit set per stage.
  typedef struct packed {
    logic vid_rd;
    logic host_rd;
  } tag_t;

  // ---------------------------------------------------------------------
  // Grant: video always wins; host only gets idle cycles, and with
  // BLANK_ONLY set only idle cycles inside blanking. RESET gates the host
  // so no handshake completes while the block is held in reset.
  // ---------------------------------------------------------------------
  logic w_grant_vid;
  logic w_grant_host;
  logic w_host_window;

  assign w_grant_vid   = VID_REQ;
  assign w_host_window = ~BLANK_ONLY | VID_BLANK;
  assign w_grant_host  = HOST_VALID & ~VID_REQ & w_host_window & RESET;
  assign HOST_READY    = w_grant_host;

  // ---------------------------------------------------------------------
  // RAM command registers
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // Register the winning request onto the RAM port; address/data hold when idle.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else if (w_grant_vid) begin
      r_mem_addr  <= VID_ADDR;
      r_mem_we    <= 1'b0;
    end else if (w_grant_host) begin
      r_mem_addr  <= HOST_ADDR;
      r_mem_we    <= HOST_WE;
      r_mem_wdata <= HOST_WDATA;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WE    = r_mem_we;
  assign MEM_WDATA = r_mem_wdata;

  // ---------------------------------------------------------------------
  // Tag pipeline. Stage 0 lines up with the registered RAM address, stage
  // RD_LAT lines up with MEM_RDATA; the return registers add the last cycle,
  // giving RD_LAT+2 cycles from grant to RVALID.
  // ---------------------------------------------------------------------
  tag_t              w_tag_in;
  tag_t              w_tag_out;
  tag_t [RD_LAT:0]   r_tag_pipe;

  assign w_tag_in.vid_rd  = w_grant_vid;
  assign w_tag_in.host_rd = w_grant_host & ~HOST_WE;
  assign w_tag_out        = r_tag_pipe[RD_LAT];

  // Shift tags one stage per cycle; reset drops every read in flight.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET) begin
      r_tag_pipe <= '0;
    end else begin
      r_tag_pipe <= {r_tag_pipe[RD_LAT-1:0], w_tag_in};
    end
  end

  logic [DATA_W-1:0] r_vid_rdata;
  logic              r_vid_rvalid;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_host_rvalid;

  // Capture returned RAM data into the owner's register; the other one holds.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET) begin
      r_vid_rdata   <= '0;
      r_vid_rvalid  <= 1'b0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_vid_rvalid  <= w_tag_out.vid_rd;
      r_host_rvalid <= w_tag_out.host_rd;
      if (w_tag_out.vid_rd)  r_vid_rdata  <= MEM_RDATA;
      if (w_tag_out.host_rd) r_host_rdata <= MEM_RDATA;
    end
  end

  assign VID_RDATA   = r_vid_rdata;
  assign VID_RVALID  = r_vid_rvalid;
  assign HOST_RDATA  = r_host_rdata;
  assign HOST_RVALID = r_host_rvalid;

  // ---------------------------------------------------------------------
  // Stall counter. The FRAME_START cycle's own stall belongs to the frame
  // that is closing, so the snapshot takes the already-incremented value.
  // ---------------------------------------------------------------------
  logic             w_stall;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] r_stall_acc;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_stall    = HOST_VALID & ~w_grant_host;
  assign w_acc_next = (w_stall && (r_stall_acc != {CNT_W{1'b1}}))
                      ? r_stall_acc + CNT_W'(1) : r_stall_acc;

  // Accumulate stalls within a frame, publish and restart at frame start.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET) begin
      r_stall_acc <= '0;
      r_stall_cnt <= '0;
    end else if (FRAME_START) begin
      r_stall_cnt <= w_acc_next;
      r_stall_acc <= '0;
    end else begin
      r_stall_acc <= w_acc_next;
    end
  end

  assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a RD_LAT=1 RAM model. Unwritten
// RAM locations read back as addr[7:0]^8'h3C.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              RESET;
  logic              VID_REQ;
  logic [ADDR_W-1:0] VID_ADDR;
  logic              VID_BLANK;
  logic              FRAME_START;
  logic [DATA_W-1:0] VID_RDATA;
  logic              VID_RVALID;
  logic              HOST_VALID;
  logic              HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_READY;
  logic [DATA_W-1:0] HOST_RDATA;
  logic              HOST_RVALID;
  logic              BLANK_ONLY;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [CNT_W-1:0]  STALL_CNT;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .CNT_W(CNT_W)) dut (
    .CLK_25MHZ(clk), .RESET(RESET),
    .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_BLANK(VID_BLANK),
    .FRAME_START(FRAME_START), .VID_RDATA(VID_RDATA), .VID_RVALID(VID_RVALID),
    .HOST_VALID(HOST_VALID), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
    .HOST_WDATA(HOST_WDATA), .HOST_READY(HOST_READY), .HOST_RDATA(HOST_RDATA),
    .HOST_RVALID(HOST_RVALID), .BLANK_ONLY(BLANK_ONLY),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .STALL_CNT(STALL_CNT)
  );

  // RAM model, one-cycle read latency
  logic [7:0] mem   [0:65535];
  bit         wr_ok [0:65535];
  always @(posedge clk) begin
    if (MEM_WE) begin
      mem[MEM_ADDR]   <= MEM_WDATA;
      wr_ok[MEM_ADDR] <= 1'b1;
    end
    MEM_RDATA <= wr_ok[MEM_ADDR] ? mem[MEM_ADDR] : (MEM_ADDR[7:0] ^ 8'h3C);
  end

  // interleave table: inputs and expected outputs per cycle
  bit         t_vreq  [0:9] = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0};
  logic [15:0] t_vaddr [0:9] = '{16'h0, 16'h0, 16'h1, 16'h2, 16'h0, 16'h3, 16'h0, 16'h0, 16'h0, 16'h0};
  bit         t_hval  [0:9] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
  logic [15:0] t_haddr [0:9] = '{16'h0, 16'h10, 16'h0, 16'h20, 16'h20, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  bit         t_rdy   [0:9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  bit         t_ev    [0:9] = '{0, 0, 0, 1, 0, 1, 1, 0, 1, 0};
  logic [7:0] t_evd   [0:9] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3D, 8'h3E, 8'h3E, 8'h3F, 8'h3F};
  bit         t_eh    [0:9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
  logic [7:0] t_ehd   [0:9] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h1C, 8'h1C, 8'h1C};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    VID_REQ = 1'b0; HOST_VALID = 1'b0; FRAME_START = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; VID_REQ = 1'b0; VID_ADDR = '0; VID_BLANK = 1'b0;
    FRAME_START = 1'b0; HOST_VALID = 1'b1; HOST_WE = 1'b0; HOST_ADDR = '0;
    HOST_WDATA = '0; BLANK_ONLY = 1'b0;

    // reset state; host blocked while in reset
    tick(); tick(); tick();
    chk("rst_ready", HOST_READY, 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_vrv", VID_RVALID, 0);
    chk("rst_hrv", HOST_RVALID, 0);
    chk("rst_stall", STALL_CNT, 0);
    HOST_VALID = 1'b0;
    RESET = 1'b1;
    tick();

    // host write 0x0010 <- 0xA5
    HOST_VALID = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h0010; HOST_WDATA = 8'hA5;
    #1 chk("wr_ready", HOST_READY, 1);
    tick(); idle();
    chk("wr_mem_we", MEM_WE, 1);
    chk("wr_mem_addr", MEM_ADDR, 16'h0010);
    chk("wr_mem_wdata", MEM_WDATA, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_no_hrv", HOST_RVALID, 0);
      chk("wr_no_vrv", VID_RVALID, 0);
    end
    chk("idle_we", MEM_WE, 0);
    chk("idle_addr_hold", MEM_ADDR, 16'h0010);

    // host read 0x0010, RVALID at grant+3
    HOST_VALID = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 16'h0010;
    #1 chk("rd_ready", HOST_READY, 1);
    tick(); idle();
    chk("rd_mem_we", MEM_WE, 0);
    tick();
    chk("rd_hrv_early", HOST_RVALID, 0);
    tick();
    chk("rd_hrv", HOST_RVALID, 1);
    chk("rd_hdata", HOST_RDATA, 8'hA5);
    chk("rd_vrv", VID_RVALID, 0);
    tick();
    chk("rd_hrv_off", HOST_RVALID, 0);
    tick();

    // interleaved video/host reads
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("il_vrv%0d", i), VID_RVALID, t_ev[i]);
      chk($sformatf("il_vd%0d", i), VID_RDATA, t_evd[i]);
      chk($sformatf("il_hrv%0d", i), HOST_RVALID, t_eh[i]);
      chk($sformatf("il_hd%0d", i), HOST_RDATA, t_ehd[i]);
      VID_REQ = t_vreq[i]; VID_ADDR = t_vaddr[i];
      HOST_VALID = t_hval[i]; HOST_WE = 1'b0; HOST_ADDR = t_haddr[i];
      #1 chk($sformatf("il_rdy%0d", i), HOST_READY, t_rdy[i]);
      tick();
    end
    idle();

    // close the frame holding the single interleave stall
    FRAME_START = 1'b1;
    tick(); idle();
    chk("stall_first", STALL_CNT, 1);

    // video held for 10 cycles, host waits
    for (int k = 0; k < 10; k++) begin
      VID_REQ = 1'b1; VID_ADDR = 16'(k);
      HOST_VALID = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h0030; HOST_WDATA = 8'h77;
      #1 chk($sformatf("vid_pri%0d", k), HOST_READY, 0);
      tick();
    end
    VID_REQ = 1'b0;
    #1 chk("host_after_vid", HOST_READY, 1);
    tick(); idle();
    chk("host_wr_we", MEM_WE, 1);
    chk("host_wr_addr", MEM_ADDR, 16'h0030);
    chk("host_wr_data", MEM_WDATA, 8'h77);
    tick();
    FRAME_START = 1'b1;
    tick(); idle();
    chk("stall_ten", STALL_CNT, 10);

    // stall coincident with FRAME_START counts in the closing frame
    VID_REQ = 1'b1; HOST_VALID = 1'b1; FRAME_START = 1'b1;
    tick(); idle();
    chk("stall_coinc", STALL_CNT, 1);

    // blank-only gating takes effect within the cycle
    BLANK_ONLY = 1'b1; VID_BLANK = 1'b0;
    HOST_VALID = 1'b1; HOST_WE = 1'b1; HOST_ADDR = 16'h0040; HOST_WDATA = 8'h11;
    #1 chk("blank_block", HOST_READY, 0);
    VID_BLANK = 1'b1;
    #1 chk("blank_open", HOST_READY, 1);
    tick(); idle();
    BLANK_ONLY = 1'b0; VID_BLANK = 1'b0;
    chk("blank_wr_addr", MEM_ADDR, 16'h0040);
    chk("blank_wr_we", MEM_WE, 1);

    // reset one cycle after a video read discards it
    tick();
    VID_REQ = 1'b1; VID_ADDR = 16'h0055;
    tick();
    VID_REQ = 1'b0; RESET = 1'b0; HOST_VALID = 1'b1;
    chk("prerst_addr", MEM_ADDR, 16'h0055);
    chk("prerst_stall", STALL_CNT, 1);
    #1 chk("inrst_ready", HOST_READY, 0);
    tick();
    chk("inrst_vrv", VID_RVALID, 0);
    chk("inrst_hrv", HOST_RVALID, 0);
    chk("inrst_addr", MEM_ADDR, 0);
    chk("inrst_we", MEM_WE, 0);
    chk("inrst_wdata", MEM_WDATA, 0);
    chk("inrst_vd", VID_RDATA, 0);
    chk("inrst_hd", HOST_RDATA, 0);
    chk("inrst_stall", STALL_CNT, 0);
    tick();
    chk("inrst_vrv2", VID_RVALID, 0);
    RESET = 1'b1; HOST_VALID = 1'b0;
    tick();
    chk("postrst_vrv", VID_RVALID, 0);
    tick();
    chk("postrst_vrv2", VID_RVALID, 0);
    chk("postrst_stall", STALL_CNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
